// File: rtl/wb_i2s.sv
// wb_i2s: Wishbone slave that feeds a stereo sample FIFO into a continuous I2S serializer
module wb_i2s #(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] DIV_RESET = 8'd7
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [1:0]  adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq,
   output logic        i2s_bclk,
   output logic        i2s_wsel,
   output logic        i2s_dout
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] level;
   logic en, irq_en, undr, ovf;
   logic [7:0] div, div_cnt;
   logic [4:0] bit_cnt, nb, nb2;
   logic [31:0] sr, rdata;
   logic acc, wr, push, push_ok, pop, full, empty, half, wrap, fall, frame, clr;
   // Bus decode, FIFO flags and serializer edge detection
   always_comb begin
      acc     = cyc_i & stb_i & ~ack_o;
      wr      = acc & we_i;
      full    = level == (AW+1)'(DEPTH);
      empty   = level == '0;
      half    = level <= (AW+1)'(DEPTH / 2);
      push    = wr & (adr_i == 2'd0) & |sel_i;
      push_ok = push & ~full;
      clr     = wr & (adr_i == 2'd1) & sel_i[2];
      wrap    = div_cnt == div;
      fall    = en & wrap & i2s_bclk;
      nb      = bit_cnt + 5'd1;
      nb2     = bit_cnt + 5'd2;
      frame   = fall & (nb == 5'd0);
      pop     = frame & ~empty;
      rdata   = adr_i == 2'd1 ? {8'(level), 6'b0, ovf, undr, 13'b0, half, empty, full} :
                adr_i == 2'd2 ? {30'b0, irq_en, en} :
                adr_i == 2'd3 ? {24'b0, div} : '0;
   end
   // Register file, sticky flags and registered interrupt; a flag set beats a same-cycle clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         en     <= 1'b0;
         irq_en <= 1'b0;
         div    <= DIV_RESET;
         undr   <= 1'b0;
         ovf    <= 1'b0;
         irq    <= 1'b0;
      end else begin
         ack_o <= acc;
         dat_o <= acc ? rdata : '0;
         if (wr & (adr_i == 2'd2) & sel_i[0]) {irq_en, en} <= dat_i[1:0];
         if (wr & (adr_i == 2'd3) & sel_i[0]) div <= dat_i[7:0];
         undr <= frame & empty | undr & ~(clr & dat_i[16]);
         ovf  <= push & full | ovf & ~(clr & dat_i[17]);
         irq  <= irq_en & half;
      end
   end
   // Sample storage; contents need no reset since level gates every read
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wp] <= dat_i;
   end
   // FIFO pointers and fill level; a push while full is dropped even alongside a pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         level <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      end
   end
   // Bit clock divider and shift register; all serial state moves on the bclk falling edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt  <= '0;
         i2s_bclk <= 1'b0;
         bit_cnt  <= '0;
         sr       <= '0;
         i2s_wsel <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         i2s_bclk <= 1'b0;
         bit_cnt  <= 5'd31;
         sr       <= '0;
         i2s_wsel <= 1'b0;
      end else begin
         div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
         if (wrap) i2s_bclk <= ~i2s_bclk;
         if (fall) begin
            bit_cnt  <= nb;
            sr       <= nb != 5'd0 ? {sr[30:0], 1'b0} : empty ? 32'd0 : mem[rp];
            i2s_wsel <= nb2[4];
         end
      end
   end
   assign i2s_dout = sr[31];
endmodule

// File: tb/tb_wb_i2s.sv
// tb_wb_i2s: directed table and sequence checks of the Wishbone I2S transmitter
module tb_wb_i2s;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0] adr = '0;
   logic [3:0] sel = '0;
   logic [31:0] dat = '0;
   logic ack, irq, bclk, wsel, dout;
   logic [31:0] dat_o;
   int checks = 0, errors = 0;
   int rise_cnt = 0, cyc_n = 0, last_rise = 0, last_per = 0, ones = 0, irq_lows = 0;
   logic bq = 1'b0, irq_watch = 1'b0;
   logic [31:0] dsh = '0, wsh = '0;

   typedef struct {
      logic        we;
      logic [1:0]  adr;
      logic [3:0]  sel;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[16];

   wb_i2s dut (
      .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .dat_i(dat), .ack_o(ack), .dat_o(dat_o), .irq(irq),
      .i2s_bclk(bclk), .i2s_wsel(wsel), .i2s_dout(dout)
   );

   always #5 clk = ~clk;

   // Receiver model: sample dout/wsel on each bclk rising edge, as an I2S DAC would
   always @(negedge clk) begin
      cyc_n++;
      if (bclk && !bq) begin
         rise_cnt++;
         dsh = {dsh[30:0], dout};
         wsh = {wsh[30:0], wsel};
         last_per = cyc_n - last_rise;
         last_rise = cyc_n;
         ones += int'(dout);
      end
      bq = bclk;
      if (irq_watch && !irq) irq_lows++;
   end

   function automatic logic [31:0] wv(input int i);
      return {16'hA000 + 16'(i), 16'h5F00 + 16'(i)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic wb(input logic w, input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
      logic got;
      got = 1'b0;
      r = '0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            r = dat_o;
            got = 1'b1;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] r;
      wb(1'b1, a, s, d, r);
   endtask

   task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      wb(1'b0, a, 4'hF, 32'd0, r);
      chk(nm, r, exp);
   endtask

   task automatic run_table(input int lo, input int hi);
      logic [31:0] r;
      for (int i = lo; i <= hi; i++) begin
         wb(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, r);
         if (!tbl[i].we) chk($sformatf("tbl%0d", i), r, tbl[i].exp);
      end
   endtask

   task automatic wait_rises(input int n, input string nm);
      int tgt;
      tgt = rise_cnt + n;
      for (int i = 0; i < n * 40 + 40 && rise_cnt < tgt; i++) @(posedge clk);
      #1;
      if (rise_cnt < tgt) chk(nm, 32'(rise_cnt), 32'(tgt));
   endtask

   initial begin
      logic [3:0] pat;
      logic prev, found;
      int o, rc;
      tbl[0]  = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0006};
      tbl[1]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0000};
      tbl[2]  = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0000_0007};
      tbl[3]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h0000_0000};
      tbl[4]  = '{1'b1, 2'd3, 4'hE, 32'h0000_00AB, 32'h0};
      tbl[5]  = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0000_0007};
      tbl[6]  = '{1'b1, 2'd3, 4'h1, 32'hFFFF_FF01, 32'h0};
      tbl[7]  = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0000_0001};
      tbl[8]  = '{1'b1, 2'd2, 4'h1, 32'h0000_0002, 32'h0};
      tbl[9]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0002};
      tbl[10] = '{1'b1, 2'd2, 4'h1, 32'hFFFF_FFFC, 32'h0};
      tbl[11] = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0000_0000};
      tbl[12] = '{1'b1, 2'd0, 4'h0, 32'h1234_5678, 32'h0};
      tbl[13] = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0006};
      tbl[14] = '{1'b1, 2'd0, 4'hF, 32'h8001_7FFE, 32'h0};
      tbl[15] = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0100_0004};
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_pins", {27'd0, ack, irq, bclk, wsel, dout}, 32'd0);
      chk("reset_dat", dat_o, 32'd0);
      // ack is a single-cycle pulse even with stb held
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1; sel = 4'hF;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         pat = {pat[2:0], ack};
      end
      cyc = 1'b0; stb = 1'b0;
      chk("ack_pulse", {28'd0, pat}, 32'hA);
      run_table(0, 15);
      // First frame: DIV = 1, one preloaded word
      wr(2'd2, 4'h1, 32'h1);
      wait_rises(1, "pre_rise");
      chk("pre_bit", {30'd0, dsh[0], wsh[0]}, 32'd0);
      wait_rises(32, "frame_rise");
      chk("frame_dout", dsh, 32'h8001_7FFE);
      chk("frame_wsel", wsh, 32'h0001_FFFE);
      chk("bclk_period", 32'(last_per), 32'd4);
      wait_rises(1, "undr_rise");
      rd("status_undr", 2'd1, 32'h0001_0006);
      // Underrun: two empty frames emit nothing
      o = ones;
      wait_rises(64, "empty_rise");
      chk("empty_dout", 32'(ones - o), 32'd0);
      wr(2'd2, 4'h1, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("disable_pins", {29'd0, bclk, wsel, dout}, 32'd0);
      rc = rise_cnt;
      repeat (20) @(posedge clk);
      chk("disable_idle", 32'(rise_cnt - rc), 32'd0);
      wr(2'd1, 4'h3, 32'h0001_0000);
      rd("undr_noclr", 2'd1, 32'h0001_0006);
      wr(2'd1, 4'h4, 32'h0001_0000);
      rd("undr_clr", 2'd1, 32'h0000_0006);
      // Overflow: 17 writes while disabled, the last one is dropped
      for (int i = 0; i < 17; i++) wr(2'd0, 4'hF, wv(i));
      rd("status_full", 2'd1, 32'h1002_0001);
      wr(2'd1, 4'hF, 32'h0002_0000);
      rd("ovf_clr", 2'd1, 32'h1000_0001);
      wr(2'd2, 4'h1, 32'h1);
      wait_rises(1, "pre_rise2");
      for (int i = 0; i < 16; i++) begin
         wait_rises(32, "fifo_rise");
         chk($sformatf("fifo_word%0d", i), dsh, wv(i));
      end
      wait_rises(32, "drop_rise");
      chk("dropped_word", dsh, 32'd0);
      wr(2'd2, 4'h1, 32'h0);
      rd("status_drained", 2'd1, 32'h0001_0006);
      wr(2'd1, 4'h4, 32'h0003_0000);
      rd("status_clean", 2'd1, 32'h0000_0006);
      // Interrupt threshold and simultaneous push/pop
      wr(2'd2, 4'h1, 32'h2);
      @(posedge clk);
      #1;
      chk("irq_empty", {31'd0, irq}, 32'd1);
      for (int i = 0; i < 9; i++) wr(2'd0, 4'hF, wv(i + 32));
      @(posedge clk);
      #1;
      chk("irq_nine", {31'd0, irq}, 32'd0);
      rd("status_nine", 2'd1, 32'h0900_0000);
      wr(2'd2, 4'h1, 32'h3);
      prev = bclk;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         found = prev & ~bclk;
         prev = bclk;
      end
      chk("first_pop", {31'd0, found}, 32'd1);
      chk("irq_at_pop", {31'd0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_after_pop", {31'd0, irq}, 32'd1);
      irq_watch = 1'b1;
      repeat (126) @(posedge clk);
      #1;
      wr(2'd0, 4'hF, 32'hFFFF_0000);
      repeat (3) @(posedge clk);
      irq_watch = 1'b0;
      chk("pushpop_irq", 32'(irq_lows), 32'd0);
      rd("pushpop_level", 2'd1, 32'h0800_0004);
      // Asynchronous reset mid-frame at bit 20
      for (int i = 0; i < 400 && wsel; i++) @(posedge clk);
      for (int i = 0; i < 400 && !wsel; i++) @(posedge clk);
      wait_rises(6, "bit20_rise");
      #2;
      chk("pre_reset_pins", {29'd0, bclk, wsel, irq}, 32'd7);
      rst_n = 1'b0;
      #1;
      chk("async_reset_pins", {28'd0, bclk, wsel, dout, irq}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_table(0, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
